// File: rtl/usb2_ep_in_packer.sv
// usb2_ep_in_packer: packs an application byte stream into endpoint IN buffers and commits each packet
module usb2_ep_in_packer #(
    parameter int MAX_PKT      = 512,
    parameter int IDLE_TIMEOUT = 255,
    parameter bit ZLP_EN       = 1'b1
) (
    input  logic        phy_clk,
    input  logic        reset_n,
    input  logic [7:0]  s_data,
    input  logic        s_valid,
    input  logic        s_last,
    output logic        s_ready,
    output logic [8:0]  buf_in_addr,
    output logic [7:0]  buf_in_data,
    output logic        buf_in_wren,
    input  logic        buf_in_ready,
    output logic        buf_in_commit,
    output logic [9:0]  buf_in_commit_len,
    input  logic        buf_in_commit_ack,
    output logic        busy,
    output logic [15:0] pkt_count
);
    typedef enum logic [1:0] {WAIT_RDY, FILL, COMMIT, RELEASE} state_t;
    state_t state, state_nx;
    logic [9:0] cnt;
    logic [15:0] timer;
    logic zlp_pend, guard, accept, full, time_out;
    assign s_ready  = state == FILL;
    assign accept   = s_valid && s_ready;
    assign full     = cnt + 10'd1 == 10'(MAX_PKT);
    assign time_out = IDLE_TIMEOUT != 0 && cnt != 10'd0 && timer == 16'(IDLE_TIMEOUT) && !accept;
    assign busy     = !(state == WAIT_RDY && cnt == 10'd0);
    always_comb begin
        state_nx = state;
        case (state)
            WAIT_RDY: state_nx = buf_in_ready ? (zlp_pend ? COMMIT : FILL) : WAIT_RDY;
            FILL:     state_nx = (accept && (full || s_last)) || time_out ? COMMIT : FILL;
            COMMIT:   state_nx = buf_in_commit && buf_in_commit_ack ? RELEASE : COMMIT;
            RELEASE:  state_nx = !buf_in_commit_ack && guard ? WAIT_RDY : RELEASE;
            default:  state_nx = WAIT_RDY;
        endcase
    end
    always_ff @(posedge phy_clk) begin
        if (!reset_n)
            state <= WAIT_RDY;
        else
            state <= state_nx;
    end
    always_ff @(posedge phy_clk) begin
        if (!reset_n) begin
            cnt               <= '0;
            timer             <= '0;
            zlp_pend          <= 1'b0;
            guard             <= 1'b0;
            buf_in_wren       <= 1'b0;
            buf_in_addr       <= '0;
            buf_in_data       <= '0;
            buf_in_commit     <= 1'b0;
            buf_in_commit_len <= '0;
            pkt_count         <= '0;
        end else begin
            buf_in_wren   <= accept;
            // commit rises only after the final write strobe has been issued
            buf_in_commit <= state == COMMIT && state_nx == COMMIT;
            guard         <= state == RELEASE && !buf_in_commit_ack && !guard;
            if (accept) begin
                buf_in_addr <= cnt[8:0];
                buf_in_data <= s_data;
                cnt         <= cnt + 10'd1;
                timer       <= '0;
            end else if (state == FILL && cnt != 10'd0 && IDLE_TIMEOUT != 0)
                timer <= timer + 16'd1;
            if (state == WAIT_RDY) begin
                timer <= '0;
                if (buf_in_ready && zlp_pend) begin
                    buf_in_commit_len <= '0;
                    zlp_pend          <= 1'b0;
                end
            end
            if (state == FILL && state_nx == COMMIT) begin
                buf_in_commit_len <= accept ? cnt + 10'd1 : cnt;
                if (ZLP_EN && accept && s_last && full)
                    zlp_pend <= 1'b1;
            end
            if (state == COMMIT && state_nx == RELEASE) begin
                cnt       <= '0;
                pkt_count <= pkt_count + 16'd1;
            end
        end
    end
endmodule

// File: tb/tb_usb2_ep_in_packer.sv
// tb_usb2_ep_in_packer: random and directed streams checked against a packet-splitting reference model
module tb_usb2_ep_in_packer;
    localparam int MAXP = 64;
    localparam int TO   = 16;
    logic        phy_clk = 1'b0;
    logic        reset_n;
    logic [7:0]  s_data;
    logic        s_valid, s_last, s_ready;
    logic [8:0]  buf_in_addr;
    logic [7:0]  buf_in_data;
    logic        buf_in_wren, buf_in_ready, buf_in_commit, buf_in_commit_ack, busy;
    logic [9:0]  buf_in_commit_len;
    logic [15:0] pkt_count;
    int n_chk = 0, n_fail = 0;
    int wr_cnt = 0, wr_err = 0, n_commit = 0;
    logic [15:0] exp_pkt = '0;
    logic [7:0] mem [0:511];
    logic [7:0] exp_bytes [$];
    int exp_len [$];
    bit auto_rearm = 1'b1, hold_ack = 1'b0;
    always #5 phy_clk = ~phy_clk;
    usb2_ep_in_packer #(.MAX_PKT(MAXP), .IDLE_TIMEOUT(TO), .ZLP_EN(1'b1)) dut (
        .phy_clk(phy_clk), .reset_n(reset_n), .s_data(s_data), .s_valid(s_valid),
        .s_last(s_last), .s_ready(s_ready), .buf_in_addr(buf_in_addr),
        .buf_in_data(buf_in_data), .buf_in_wren(buf_in_wren), .buf_in_ready(buf_in_ready),
        .buf_in_commit(buf_in_commit), .buf_in_commit_len(buf_in_commit_len),
        .buf_in_commit_ack(buf_in_commit_ack), .busy(busy), .pkt_count(pkt_count)
    );
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask
    // the model: a transfer splits into full packets, then the remainder, then a ZLP if it ended on a boundary
    task automatic plan(input int n, input bit last);
        int rem = n;
        while (rem >= MAXP) begin
            exp_len.push_back(MAXP);
            rem -= MAXP;
        end
        if (last && rem > 0) exp_len.push_back(rem);
        if (last && rem == 0 && n > 0) exp_len.push_back(0);
    endtask
    task automatic send_byte(input logic [7:0] d, input bit l);
        int k = 0;
        s_valid = 1'b1;
        s_data  = d;
        s_last  = l;
        while (!s_ready && k < 4000) begin
            @(negedge phy_clk);
            k++;
        end
        if (k >= 4000) check("s_ready_wait", 32'(k), 0);
        @(negedge phy_clk);
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask
    task automatic send_q(input logic [7:0] q [$], input bit last, input int max_gap);
        plan(q.size(), last);
        foreach (q[i]) exp_bytes.push_back(q[i]);
        foreach (q[i]) begin
            send_byte(q[i], last && i == q.size() - 1);
            repeat ($urandom_range(0, max_gap)) @(negedge phy_clk);
        end
    endtask
    task automatic send_rand(input int n, input bit last, input int max_gap);
        logic [7:0] q [$];
        for (int i = 0; i < n; i++) q.push_back(8'($urandom));
        send_q(q, last, max_gap);
    endtask
    task automatic wait_idle();
        int k = 0;
        while (!(exp_len.size() == 0 && s_ready) && k < 6000) begin
            @(negedge phy_clk);
            k++;
        end
        check("idle_reached", 32'(k < 6000), 1);
    endtask
    task automatic reset_checks(input string tag);
        check({tag, "_s_ready"}, 32'(s_ready), 0);
        check({tag, "_wren"}, 32'(buf_in_wren), 0);
        check({tag, "_commit"}, 32'(buf_in_commit), 0);
        check({tag, "_len"}, 32'(buf_in_commit_len), 0);
        check({tag, "_addr"}, 32'(buf_in_addr), 0);
        check({tag, "_data"}, 32'(buf_in_data), 0);
        check({tag, "_pkt_count"}, 32'(pkt_count), 0);
        check({tag, "_busy"}, 32'(busy), 0);
    endtask
    always @(negedge phy_clk) begin
        if (!reset_n || buf_in_commit_ack) begin
            wr_cnt = 0;
            wr_err = 0;
        end else if (buf_in_wren) begin
            check("wr_commit_overlap", 32'(buf_in_commit), 0);
            if (int'(buf_in_addr) != wr_cnt) wr_err++;
            mem[buf_in_addr] = buf_in_data;
            wr_cnt++;
        end
    end
    // endpoint model: verifies each committed packet, acks it over 4 cycles, then re-arms
    initial begin
        buf_in_ready      = 1'b1;
        buf_in_commit_ack = 1'b0;
        forever begin
            @(negedge phy_clk);
            if (reset_n && buf_in_commit) begin
                int l, el, bad;
                bit held;
                held = hold_ack;
                n_commit++;
                l  = int'(buf_in_commit_len);
                el = exp_len.size() > 0 ? exp_len.pop_front() : -1;
                check("commit_len", 32'(l), 32'(el));
                check("write_count", 32'(wr_cnt), 32'(l));
                check("addr_seq", 32'(wr_err), 0);
                bad = 0;
                for (int i = 0; i < l; i++)
                    if (exp_bytes.size() == 0 || mem[i] !== exp_bytes.pop_front()) bad++;
                check("packet_data", 32'(bad), 0);
                repeat ($urandom_range(0, 3)) @(negedge phy_clk);
                if (!held) check("commit_hold", 32'(buf_in_commit), 1);
                while (held && buf_in_commit) @(negedge phy_clk);
                if (buf_in_commit && reset_n) begin
                    buf_in_commit_ack = 1'b1;
                    buf_in_ready      = 1'b0;
                    @(negedge phy_clk);
                    check("commit_drop", 32'(buf_in_commit), 0);
                    exp_pkt++;
                    check("pkt_count", 32'(pkt_count), 32'(exp_pkt));
                    repeat (3) @(negedge phy_clk);
                    buf_in_commit_ack = 1'b0;
                    repeat ($urandom_range(1, 4)) @(negedge phy_clk);
                    while (!auto_rearm) @(negedge phy_clk);
                    buf_in_ready = 1'b1;
                end
            end
        end
    end
    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end
    initial begin
        logic [7:0] q [$];
        int k, n0, rdy_hi, wr_hi;
        reset_n = 1'b0;
        s_valid = 1'b0;
        s_last  = 1'b0;
        s_data  = '0;
        repeat (3) @(negedge phy_clk);
        reset_checks("reset");
        reset_n = 1'b1;
        for (int i = 0; i < 512; i++) q.push_back(8'(i));
        send_q(q, 1'b0, 0);
        wait_idle();
        check("pkt_count_512", 32'(pkt_count), 8);
        q = '{8'hA1, 8'hB2, 8'hC3};
        send_q(q, 1'b1, 1);
        wait_idle();
        send_rand(MAXP, 1'b1, 1);
        wait_idle();
        check("pkt_count_zlp", 32'(pkt_count), 11);
        exp_len.push_back(5);
        send_rand(5, 1'b0, 0);
        k = 0;
        while (!buf_in_commit && k < 40) begin
            @(negedge phy_clk);
            k++;
        end
        check("timeout_window", 32'(k >= TO && k <= TO + 3), 1);
        wait_idle();
        n0 = n_commit;
        repeat (100) @(negedge phy_clk);
        check("no_empty_commit", 32'(n_commit), 32'(n0));
        auto_rearm = 1'b0;
        n0 = int'(exp_pkt);
        send_rand(3, 1'b1, 0);
        k = 0;
        while (int'(exp_pkt) == n0 && k < 200) begin
            @(negedge phy_clk);
            k++;
        end
        rdy_hi = 0;
        wr_hi  = 0;
        repeat (100) begin
            @(negedge phy_clk);
            rdy_hi += int'(s_ready);
            wr_hi  += int'(buf_in_wren);
        end
        check("hold_s_ready", 32'(rdy_hi), 0);
        check("hold_writes", 32'(wr_hi), 0);
        auto_rearm = 1'b1;
        k = 0;
        while (!buf_in_ready && k < 50) begin
            @(negedge phy_clk);
            k++;
        end
        @(negedge phy_clk);
        check("fill_after_ready", 32'(s_ready), 1);
        send_rand(4, 1'b1, 0);
        wait_idle();
        for (int t = 0; t < 10; t++) begin
            int n;
            n = $urandom_range(0, 3) == 0 ? MAXP * $urandom_range(1, 2) : $urandom_range(1, 150);
            send_rand(n, 1'b1, 2);
        end
        wait_idle();
        check("pkt_count_rand", 32'(pkt_count), 32'(exp_pkt));
        send_byte(8'h11, 1'b0);
        send_byte(8'h22, 1'b0);
        reset_n = 1'b0;
        exp_len.delete();
        exp_bytes.delete();
        exp_pkt = '0;
        @(negedge phy_clk);
        reset_checks("rst_fill");
        reset_n = 1'b1;
        send_rand(5, 1'b1, 1);
        wait_idle();
        hold_ack = 1'b1;
        send_rand(3, 1'b1, 0);
        k = 0;
        while (!buf_in_commit && k < 50) begin
            @(negedge phy_clk);
            k++;
        end
        check("commit_seen", 32'(buf_in_commit), 1);
        reset_n = 1'b0;
        exp_len.delete();
        exp_bytes.delete();
        exp_pkt = '0;
        @(negedge phy_clk);
        reset_checks("rst_commit");
        hold_ack = 1'b0;
        reset_n  = 1'b1;
        send_rand(10, 1'b1, 2);
        wait_idle();
        check("pkt_count_final", 32'(pkt_count), 32'(exp_pkt));
        check("bytes_left", 32'(exp_bytes.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
